pc_sequencer: RTL and testbench

Parametrised program-counter unit for the MIPS_32 fetch stage. It generalises the fixed PC+4 adder into a registered PC with several features:
- configurable step and width
- branch, jump and register-jump redirects
- optional MIPS branch delay slot
- exception vectoring with EPC capture, and ERET
- stall and a fetch-valid qualifier

It sits between the control/branch-resolve logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the fetch stage.
// Handles sequential stepping, branch/jump/register-jump redirects with an
// optional delay slot, exception vectoring with EPC capture, ERET and stall.
module pc_sequencer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STEP       = 4,
  parameter logic [31:0] RESET_VEC  = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC    = 32'h8000_0180,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [15:0]       branch_off_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_tgt_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_tgt_i,
  input  logic              exc_i,
  input  logic              eret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              misalign_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DSLOT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LP_RESET_VEC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] LP_EXC_VEC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] LP_STEP      = ADDR_W'(STEP);

  state_t            r_state, r_state_next;
  logic [ADDR_W-1:0] r_pc, r_pc_next;
  logic [ADDR_W-1:0] r_epc, r_epc_next;
  logic [ADDR_W-1:0] r_pend, r_pend_next;
  logic              r_misalign, r_misalign_next;

  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_target;
  logic              w_jr_misalign;
  logic              w_redirect;

  // Link value and candidate redirect targets (all adds wrap modulo 2^ADDR_W).
  assign w_pc_plus = r_pc + LP_STEP;
  assign w_br_tgt  = w_pc_plus + {{(ADDR_W-18){branch_off_i[15]}}, branch_off_i, 2'b00};
  assign w_j_tgt   = {w_pc_plus[ADDR_W-1:28], jump_tgt_i, 2'b00};

  // jr outranks jump and branch; a misaligned jr still wins and so
  // suppresses the lower-priority requests in the same cycle.
  assign w_jr_misalign = jr_i & (jr_tgt_i[1:0] != 2'b00);
  assign w_redirect    = jr_i ? ~w_jr_misalign : (jump_i | branch_i);

  // Select the winning redirect target.
  always_comb begin
    w_target = w_br_tgt;
    if (jr_i) begin
      w_target = jr_tgt_i;
    end else if (jump_i) begin
      w_target = w_j_tgt;
    end
  end

  // Next-state and next-register computation for the sequencer FSM.
  always_comb begin
    r_state_next    = r_state;
    r_pc_next       = r_pc;
    r_epc_next      = r_epc;
    r_pend_next     = r_pend;
    r_misalign_next = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // One settling cycle after reset: every request is ignored.
        r_state_next = ST_RUN;
      end
      ST_RUN, ST_DSLOT: begin
        if (exc_i) begin
          // Exceptions act through stall; in a delay slot the EPC points
          // back at the branch so the whole pair is re-executed.
          r_pc_next    = LP_EXC_VEC;
          r_state_next = ST_RUN;
          r_pend_next  = '0;
          r_epc_next   = (r_state == ST_DSLOT) ? (r_pc - LP_STEP) : r_pc;
        end else if (stall_i) begin
          // Hold everything; redirects presented now are simply dropped.
        end else if (eret_i) begin
          r_pc_next    = r_epc;
          r_state_next = ST_RUN;
          r_pend_next  = '0;
        end else if (r_state == ST_DSLOT) begin
          // Delay-slot fetch done: take the latched target, ignore new redirects.
          r_pc_next    = r_pend;
          r_state_next = ST_RUN;
          r_pend_next  = '0;
        end else begin
          r_misalign_next = w_jr_misalign;
          if (w_redirect && (DELAY_SLOT != 0)) begin
            r_pend_next  = w_target;
            r_pc_next    = w_pc_plus;
            r_state_next = ST_DSLOT;
          end else if (w_redirect) begin
            r_pc_next = w_target;
          end else begin
            r_pc_next = w_pc_plus;
          end
        end
      end
      default: begin
        r_state_next = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= LP_RESET_VEC;
      r_epc      <= '0;
      r_pend     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= r_state_next;
      r_pc       <= r_pc_next;
      r_epc      <= r_epc_next;
      r_pend     <= r_pend_next;
      r_misalign <= r_misalign_next;
    end
  end

  assign pc_o          = r_pc;
  assign pc_plus_o     = w_pc_plus;
  assign epc_o         = r_epc;
  assign misalign_o    = r_misalign;
  assign state_o       = r_state;
  assign fetch_valid_o = (r_state != ST_BOOT) & ~stall_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a transaction-level reference model. Instance A uses a delay slot,
// instance B redirects immediately.
module tb_pc_sequencer;

  typedef struct packed {
    logic        stall;
    logic        branch;
    logic [15:0] off;
    logic        jump;
    logic [25:0] jtgt;
    logic        jr;
    logic [31:0] jrtgt;
    logic        exc;
    logic        eret;
  } in_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] pend;
    bit          boot;
    bit          have_pend;
    bit          mis;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in_a, in_b;

  logic [31:0] pc_a, plus_a, epc_a, pc_b, plus_b, epc_b;
  logic        fv_a, mis_a, fv_b, mis_b;
  logic [1:0]  st_a, st_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .STEP(4), .DELAY_SLOT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .stall_i(in_a.stall), .branch_i(in_a.branch),
    .branch_off_i(in_a.off), .jump_i(in_a.jump), .jump_tgt_i(in_a.jtgt),
    .jr_i(in_a.jr), .jr_tgt_i(in_a.jrtgt), .exc_i(in_a.exc), .eret_i(in_a.eret),
    .pc_o(pc_a), .pc_plus_o(plus_a), .fetch_valid_o(fv_a), .epc_o(epc_a),
    .misalign_o(mis_a), .state_o(st_a)
  );

  pc_sequencer #(.ADDR_W(32), .STEP(4), .DELAY_SLOT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .stall_i(in_b.stall), .branch_i(in_b.branch),
    .branch_off_i(in_b.off), .jump_i(in_b.jump), .jump_tgt_i(in_b.jtgt),
    .jr_i(in_b.jr), .jr_tgt_i(in_b.jrtgt), .exc_i(in_b.exc), .eret_i(in_b.eret),
    .pc_o(pc_b), .pc_plus_o(plus_b), .fetch_valid_o(fv_b), .epc_o(epc_b),
    .misalign_o(mis_b), .state_o(st_b)
  );

  // Reference model: one clock of architectural behaviour from the rules.
  function automatic mdl_t mdl_step(mdl_t m, in_t x, bit ds);
    mdl_t n;
    logic [31:0] tgt;
    bit          take;
    n = m;
    n.mis = 0;
    if (m.boot) begin
      n.boot = 0;
      return n;
    end
    if (x.exc) begin
      n.epc = m.have_pend ? (m.pc - 32'd4) : m.pc;
      n.pc = 32'h8000_0180;
      n.have_pend = 0;
    end else if (x.stall) begin
      // frozen
    end else if (x.eret) begin
      n.pc = m.epc;
      n.have_pend = 0;
    end else if (m.have_pend) begin
      n.pc = m.pend;
      n.have_pend = 0;
    end else begin
      take = 0;
      tgt = 32'd0;
      if (x.jr) begin
        if (x.jrtgt % 4 != 0) n.mis = 1;
        else begin take = 1; tgt = x.jrtgt; end
      end else if (x.jump) begin
        take = 1;
        tgt = ((m.pc + 32'd4) & 32'hF000_0000) | (32'(x.jtgt) * 4);
      end else if (x.branch) begin
        take = 1;
        tgt = m.pc + 32'd4 + 32'($signed(x.off)) * 4;
      end
      if (take && ds) begin
        n.pend = tgt;
        n.have_pend = 1;
        n.pc = m.pc + 32'd4;
      end else if (take) begin
        n.pc = tgt;
      end else begin
        n.pc = m.pc + 32'd4;
      end
    end
    return n;
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x = '0;
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    logic [31:0] t;
    x = '0;
    x.stall  = ($urandom_range(0, 99) < 15);
    x.exc    = ($urandom_range(0, 99) < 3);
    x.eret   = ($urandom_range(0, 99) < 5);
    x.jr     = ($urandom_range(0, 99) < 12);
    x.jump   = ($urandom_range(0, 99) < 12);
    x.branch = ($urandom_range(0, 99) < 18);
    x.off    = 16'($urandom());
    x.jtgt   = 26'($urandom());
    t = $urandom();
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    x.jrtgt = t;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park instance A at addr via an aligned jr through its delay slot.
  task automatic goto_a(input logic [31:0] addr);
    in_a = idle_in();
    in_a.jr = 1'b1;
    in_a.jrtgt = addr;
    tick();
    in_a = idle_in();
    tick();
  endtask

  // Park instance B at addr via an immediate jr.
  task automatic goto_b(input logic [31:0] addr);
    in_b = idle_in();
    in_b.jr = 1'b1;
    in_b.jrtgt = addr;
    tick();
    in_b = idle_in();
  endtask

  task automatic test_reset();
    in_a = idle_in();
    in_b = idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (pc_a !== 32'hBFC0_0000) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc_a, 32'hBFC0_0000); end
    tests_run++;
    if (epc_a !== 32'h0 || mis_a !== 1'b0 || st_a !== 2'd0 || fv_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state: epc %h mis %b st %0d fv %b expected 0 0 0 0", epc_a, mis_a, st_a, fv_a);
    end
    tests_run++;
    if (plus_a !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL reset_plus: got %h expected %h", plus_a, 32'hBFC0_0004); end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (pc_a !== 32'hBFC0_0000 || st_a !== 2'd1 || fv_a !== 1'b1) begin
      tests_failed++; $display("FAIL boot_hold: pc %h st %0d fv %b expected bfc00000 1 1", pc_a, st_a, fv_a);
    end
    tick();
    tests_run++;
    if (pc_a !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL run1: got %h expected %h", pc_a, 32'hBFC0_0004); end
    tick();
    tests_run++;
    if (pc_a !== 32'hBFC0_0008) begin tests_failed++; $display("FAIL run2: got %h expected %h", pc_a, 32'hBFC0_0008); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pc_a !== 32'hBFC0_0000 || st_a !== 2'd0) begin
      tests_failed++; $display("FAIL async_reset: pc %h st %0d expected bfc00000 0", pc_a, st_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (pc_a !== 32'hBFC0_0000 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL reboot: pc %h st %0d expected bfc00000 1", pc_a, st_a);
    end
  endtask

  task automatic test_branch_dslot();
    goto_a(32'h0040_0010);
    in_a.branch = 1'b1;
    in_a.off = 16'hFFFC;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0014 || st_a !== 2'd2) begin
      tests_failed++; $display("FAIL br_slot: pc %h st %0d expected 00400014 2", pc_a, st_a);
    end
    in_a = idle_in();
    in_a.jump = 1'b1;
    in_a.jtgt = 26'h3FF_FFFF;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0004 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL br_target: pc %h st %0d expected 00400004 1", pc_a, st_a);
    end
    in_a = idle_in();
  endtask

  task automatic test_jump_jr();
    goto_a(32'h0040_0020);
    in_a.jump = 1'b1;
    in_a.jtgt = 26'h010_0000;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0024 || st_a !== 2'd2) begin
      tests_failed++; $display("FAIL j_slot: pc %h st %0d expected 00400024 2", pc_a, st_a);
    end
    in_a = idle_in();
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0000) begin tests_failed++; $display("FAIL j_target: got %h expected %h", pc_a, 32'h0040_0000); end
    in_a.jr = 1'b1;
    in_a.jrtgt = 32'h0040_0102;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0004 || mis_a !== 1'b1 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL jr_misalign: pc %h mis %b st %0d expected 00400004 1 1", pc_a, mis_a, st_a);
    end
    in_a.jr = 1'b1;
    in_a.jrtgt = 32'h0040_0201;
    in_a.branch = 1'b1;
    in_a.off = 16'h0040;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0008 || mis_a !== 1'b1 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL jr_mis_drop: pc %h mis %b st %0d expected 00400008 1 1", pc_a, mis_a, st_a);
    end
    in_a = idle_in();
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_000C || mis_a !== 1'b0) begin
      tests_failed++; $display("FAIL mis_pulse: pc %h mis %b expected 0040000c 0", pc_a, mis_a);
    end
  endtask

  task automatic test_exc_eret();
    goto_a(32'h0040_0010);
    in_a.branch = 1'b1;
    in_a.off = 16'hFFFC;
    tick();
    in_a = idle_in();
    in_a.stall = 1'b1;
    in_a.exc = 1'b1;
    tick();
    tests_run++;
    if (pc_a !== 32'h8000_0180 || epc_a !== 32'h0040_0010 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL exc_dslot: pc %h epc %h st %0d expected 80000180 00400010 1", pc_a, epc_a, st_a);
    end
    in_a = idle_in();
    in_a.eret = 1'b1;
    in_a.jr = 1'b1;
    in_a.jrtgt = 32'h0000_1000;
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0010 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL eret: pc %h st %0d expected 00400010 1", pc_a, st_a);
    end
    in_a = idle_in();
    in_a.exc = 1'b1;
    in_a.jr = 1'b1;
    in_a.jrtgt = 32'h0000_2000;
    tick();
    tests_run++;
    if (pc_a !== 32'h8000_0180 || epc_a !== 32'h0040_0010 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL exc_run: pc %h epc %h st %0d expected 80000180 00400010 1", pc_a, epc_a, st_a);
    end
    in_a = idle_in();
  endtask

  task automatic test_stall();
    goto_a(32'h0040_0100);
    in_a.stall = 1'b1;
    in_a.branch = 1'b1;
    in_a.off = 16'h0010;
    #1;
    tests_run++;
    if (fv_a !== 1'b0) begin tests_failed++; $display("FAIL stall_fv: got %b expected 0", fv_a); end
    tick();
    in_a.branch = 1'b0;
    tick();
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0100 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL stall_hold: pc %h st %0d expected 00400100 1", pc_a, st_a);
    end
    in_a.stall = 1'b0;
    #1;
    tests_run++;
    if (fv_a !== 1'b1) begin tests_failed++; $display("FAIL unstall_fv: got %b expected 1", fv_a); end
    tick();
    tests_run++;
    if (pc_a !== 32'h0040_0104 || st_a !== 2'd1) begin
      tests_failed++; $display("FAIL stall_release: pc %h st %0d expected 00400104 1", pc_a, st_a);
    end
  endtask

  task automatic test_wrap_nods();
    goto_a(32'hFFFF_FFFC);
    tests_run++;
    if (plus_a !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_plus: got %h expected 00000000", plus_a); end
    tick();
    tests_run++;
    if (pc_a !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_pc: got %h expected 00000000", pc_a); end
    goto_b(32'h0040_0010);
    tests_run++;
    if (pc_b !== 32'h0040_0010 || st_b !== 2'd1) begin
      tests_failed++; $display("FAIL nods_jr: pc %h st %0d expected 00400010 1", pc_b, st_b);
    end
    in_b.branch = 1'b1;
    in_b.off = 16'hFFFC;
    tick();
    tests_run++;
    if (pc_b !== 32'h0040_0004 || st_b !== 2'd1) begin
      tests_failed++; $display("FAIL nods_branch: pc %h st %0d expected 00400004 1", pc_b, st_b);
    end
    in_b = idle_in();
  endtask

  task automatic test_random();
    mdl_t ma, mb;
    in_a = idle_in();
    in_b = idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ma.pc = 32'hBFC0_0000; ma.epc = '0; ma.pend = '0; ma.boot = 1; ma.have_pend = 0; ma.mis = 0;
    mb = ma;
    for (int i = 0; i < 600; i++) begin
      in_a = rand_in();
      in_b = rand_in();
      #1;
      tests_run++;
      if (fv_a !== (!ma.boot && !in_a.stall) || fv_b !== (!mb.boot && !in_b.stall)) begin
        tests_failed++; $display("FAIL rnd_fv[%0d]: got %b/%b expected %b/%b", i, fv_a, fv_b,
                                 !ma.boot && !in_a.stall, !mb.boot && !in_b.stall);
      end
      @(posedge clk);
      ma = mdl_step(ma, in_a, 1'b1);
      mb = mdl_step(mb, in_b, 1'b0);
      #1;
      tests_run++;
      if (pc_a !== ma.pc || plus_a !== ma.pc + 32'd4 || epc_a !== ma.epc || mis_a !== ma.mis ||
          st_a !== (ma.boot ? 2'd0 : (ma.have_pend ? 2'd2 : 2'd1))) begin
        tests_failed++; $display("FAIL rnd_a[%0d]: pc %h epc %h mis %b st %0d expected %h %h %b boot%0d pend%0d",
                                 i, pc_a, epc_a, mis_a, st_a, ma.pc, ma.epc, ma.mis, ma.boot, ma.have_pend);
      end
      tests_run++;
      if (pc_b !== mb.pc || plus_b !== mb.pc + 32'd4 || epc_b !== mb.epc || mis_b !== mb.mis ||
          st_b !== (mb.boot ? 2'd0 : 2'd1)) begin
        tests_failed++; $display("FAIL rnd_b[%0d]: pc %h epc %h mis %b st %0d expected %h %h %b boot%0d",
                                 i, pc_b, epc_b, mis_b, st_b, mb.pc, mb.epc, mb.mis, mb.boot);
      end
    end
    in_a = idle_in();
    in_b = idle_in();
  endtask

  initial begin
    in_a = '0;
    in_b = '0;
    #1;
    test_reset();
    test_branch_dslot();
    test_jump_jr();
    test_exc_eret();
    test_stall();
    test_wrap_nods();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
